// File: rtl/spi_slave_regs.sv
// SPI slave front-end for a small addressed register bank: command byte (R/W + start address)
// followed by auto-incrementing data words, with all SPI pins oversampled in the clk domain.
module spi_slave_regs #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ucSCLK,
  input  logic                   ucMOSI,
  output logic                   ucMISO,
  input  logic                   ucSEL_,
  input  logic [NREGS*WIDTH-1:0] reg_in,
  output logic [NREGS*WIDTH-1:0] reg_out,
  output logic                   wr_stb,
  output logic [AW-1:0]          wr_addr
);

  localparam int RW = ((WIDTH > 8) ? WIDTH : 8) - 1;
  localparam int CW = 6;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

  logic sclk_s1_q, sclk_s2_q, sclk_d_q;
  logic sel_s1_q, sel_s2_q, sel_d_q;
  logic mosi_s1_q, mosi_s2_q;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          rx_q, rx_d;
  logic [WIDTH-1:0]       tx_q, tx_d;
  logic                   miso_q, miso_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   oor_q, oor_d;
  logic                   rw_q, rw_d;
  logic [NREGS*WIDTH-1:0] reg_q, reg_d;
  logic                   wr_stb_q, wr_stb_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [1:0]             settle_q, settle_d;
  logic                   armed_q, armed_d;

  // NOTE: asynchronous reset with non-blocking assignments only; every stage, including the sync chain, gets a defined value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1_q <= CPOL;
      sclk_s2_q <= CPOL;
      sclk_d_q  <= CPOL;
      sel_s1_q  <= 1'b1;
      sel_s2_q  <= 1'b1;
      sel_d_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= ucSCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_d_q  <= sclk_s2_q;
      sel_s1_q  <= ucSEL_;
      sel_s2_q  <= sel_s1_q;
      sel_d_q   <= sel_s2_q;
      mosi_s1_q <= ucMOSI;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  logic sclk_rise, sclk_fall, sample_edge, shift_edge, sel_fall;
  assign sclk_rise   = sclk_s2_q & ~sclk_d_q;
  assign sclk_fall   = ~sclk_s2_q & sclk_d_q;
  assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
  assign shift_edge  = (CPOL == CPHA) ? sclk_fall : sclk_rise;
  assign sel_fall    = sel_d_q & ~sel_s2_q;

  logic [7:0]       cmd_byte;
  logic             cmd_oor;
  logic [AW-1:0]    cmd_addr, next_addr;
  logic [WIDTH-1:0] data_word, cmd_rd_word, next_rd_word;

  assign cmd_byte     = {rx_q[6:0], mosi_s2_q};
  assign cmd_oor      = {1'b0, cmd_byte[6:0]} >= 8'(NREGS);
  assign cmd_addr     = cmd_byte[AW-1:0];
  assign data_word    = {rx_q[WIDTH-2:0], mosi_s2_q};
  assign next_addr    = (addr_q == AW'(NREGS - 1)) ? '0 : addr_q + AW'(1);
  assign cmd_rd_word  = cmd_oor ? '0 : reg_in[cmd_addr*WIDTH +: WIDTH];
  assign next_rd_word = oor_q ? '0 : reg_in[next_addr*WIDTH +: WIDTH];

  // A frame already running when reset releases must be ignored, so starts need a seen-high SEL_.
  always_comb begin
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & sel_s2_q);
  end

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    addr_d    = addr_q;
    oor_d     = oor_q;
    rw_d      = rw_q;
    reg_d     = reg_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;

    if (state_q != S_IDLE && sel_s2_q) begin
      state_d = S_IDLE;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          miso_d = 1'b0;
          if (armed_q && sel_fall) begin
            state_d = S_CMD;
            cnt_d   = '0;
            tx_d    = '0;
          end
        end
        S_CMD: begin
          if (sample_edge) begin
            rx_d  = {rx_q[RW-2:0], mosi_s2_q};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(7)) begin
              state_d = S_DATA;
              cnt_d   = '0;
              rw_d    = cmd_byte[7];
              oor_d   = cmd_oor;
              addr_d  = cmd_addr;
              if (!cmd_byte[7]) begin
                tx_d = cmd_rd_word;
                if (!CPHA) miso_d = cmd_rd_word[WIDTH-1];
              end
            end
          end else if (shift_edge) begin
            miso_d = tx_q[WIDTH-1];
            tx_d   = {tx_q[WIDTH-2:0], 1'b0};
          end
        end
        S_DATA: begin
          if (sample_edge) begin
            rx_d  = {rx_q[RW-2:0], mosi_s2_q};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              cnt_d = '0;
              if (rw_q && !oor_q) begin
                reg_d[addr_q*WIDTH +: WIDTH] = data_word;
                wr_stb_d  = 1'b1;
                wr_addr_d = addr_q;
              end
              if (!rw_q) begin
                tx_d = next_rd_word;
                if (!CPHA) miso_d = next_rd_word[WIDTH-1];
              end
              // Out-of-range starts stay out of range until the frame ends.
              if (!oor_q) addr_d = next_addr;
            end
          end else if (shift_edge) begin
            miso_d = tx_q[WIDTH-1];
            tx_d   = {tx_q[WIDTH-2:0], 1'b0};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: the register bank drives board logic, so it is reset like any other state (it is flops, not a RAM).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      addr_q    <= '0;
      oor_q     <= 1'b0;
      rw_q      <= 1'b0;
      reg_q     <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      settle_q  <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      addr_q    <= addr_d;
      oor_q     <= oor_d;
      rw_q      <= rw_d;
      reg_q     <= reg_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
    end
  end

  assign ucMISO  = miso_q;
  assign reg_out = reg_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;

endmodule
